// File: rtl/adc_sampler_pkg.sv
// adc_sampler shared types and constants.
// FSM state encoding and ADC data/channel widths.
package adc_sampler_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 5;

  localparam logic [ADC_DATA_W-1:0] MID_SCALE = 12'h800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/adc_sampler_sample_fifo.sv
// sample_fifo: first-word-fall-through sample buffer.
// A pop frees a slot before a same-cycle push when full.
module sample_fifo
  import adc_sampler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = ADC_DATA_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_pop;
  logic         do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

  // Head reads as zero while empty so the output has a reset value.
  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: paced ADC conversions into a FWFT sample stream.
// ADC_SAMPLER_SIGNED_EN: emit samples as two's-complement around mid-scale.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int DIV        = 6250,
  parameter int CHANNEL    = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock_clk,
  input  logic                  reset_sink_reset_n,
  input  logic                  enable,
  input  logic                  clear_flags,
  output logic                  command_valid,
  output logic [ADC_CH_W-1:0]   command_channel,
  output logic                  command_startofpacket,
  output logic                  command_endofpacket,
  input  logic                  command_ready,
  input  logic                  response_valid,
  input  logic [ADC_CH_W-1:0]   response_channel,
  input  logic [ADC_DATA_W-1:0] response_data,
  input  logic                  response_startofpacket,
  input  logic                  response_endofpacket,
  output logic                  sample_valid,
  output logic [ADC_DATA_W-1:0] sample_data,
  input  logic                  sample_ready,
  output logic                  overflow,
  output logic                  missed_tick,
  output logic                  timeout_err
);

  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  ovf_q, ovf_d;
  logic                  miss_q, miss_d;
  logic                  tmo_q, tmo_d;
  logic                  tick;
  logic                  resp_hit;
  logic                  push;
  logic                  to_hit;
  logic                  full;
  logic                  empty;
  logic [ADC_DATA_W-1:0] push_data;
  logic                  unused_sop_eop;

  assign unused_sop_eop = response_startofpacket ^ response_endofpacket;

  assign command_channel       = ADC_CH_W'(CHANNEL);
  assign command_startofpacket = 1'b1;
  assign command_endofpacket   = 1'b1;
  assign command_valid         = (state_q == CMD);

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  assign resp_hit = response_valid &&
                    (response_channel == ADC_CH_W'(CHANNEL));

`ifdef ADC_SAMPLER_SIGNED_EN
  assign push_data = response_data - MID_SCALE;
`else
  assign push_data = response_data;
`endif

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    push    = 1'b0;
    to_hit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick && enable) state_d = CMD;
      end
      CMD: begin
        if (command_ready) begin
          state_d = WAIT;
          to_d    = '0;
        end
      end
      WAIT: begin
        if (resp_hit) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set beats clear when both land in the same cycle.
  assign ovf_d  = (push && full && !sample_ready) |
                  (ovf_q & ~clear_flags);
  assign miss_d = (tick && state_q != IDLE) |
                  (miss_q & ~clear_flags);
  assign tmo_d  = to_hit | (tmo_q & ~clear_flags);

  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      ovf_q   <= 1'b0;
      miss_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      ovf_q   <= ovf_d;
      miss_q  <= miss_d;
      tmo_q   <= tmo_d;
    end
  end

  assign overflow     = ovf_q;
  assign missed_tick  = miss_q;
  assign timeout_err  = tmo_q;
  assign sample_valid = !empty;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADC_DATA_W)
  ) u_fifo (
    .clk_i   (clock_clk),
    .rst_ni  (reset_sink_reset_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (sample_ready),
    .data_o  (sample_data),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule
